// File: rtl/ctrl_unit.sv
// Instruction decode and run/wait/halt/fault sequencing for a small datapath with a hardware return stack.
// Outputs are combinational from opcode/flags/state (zero latency); pc_en=0 stalls the PC and instruction.
module ctrl_unit #(
   parameter int STACK_DEPTH = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] opcode,
   input  logic        z,
   input  logic        carry,
   input  logic        ev_req,
   output logic        s_inc,
   output logic        s_inm,
   output logic        we3,
   output logic        wez,
   output logic        push,
   output logic        pop,
   output logic [2:0]  op_alu,
   output logic        pc_en,
   output logic        ev_ack,
   output logic        halted,
   output logic        fault,
   output logic [3:0]  depth
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_WAIT  = 2'd1,
      ST_HALT  = 2'd2,
      ST_FAULT = 2'd3
   } state_t;

   localparam logic [3:0] MAX_DEPTH = 4'(STACK_DEPTH);

   state_t     state_q, state_d;
   logic [3:0] depth_q, depth_d;
   logic [3:0] major;
   logic [3:0] sub;
   logic       stack_full;
   logic       stack_empty;
   logic       unused_opcode;

   assign major         = opcode[15:12];
   assign sub           = opcode[11:8];
   assign unused_opcode = ^opcode[7:0];
   assign stack_full    = (depth_q >= MAX_DEPTH);
   assign stack_empty   = (depth_q == 4'd0);

   always_comb begin
      s_inc   = 1'b1;
      s_inm   = 1'b0;
      we3     = 1'b0;
      wez     = 1'b0;
      push    = 1'b0;
      pop     = 1'b0;
      op_alu  = 3'b000;
      pc_en   = 1'b1;
      ev_ack  = 1'b0;
      state_d = state_q;
      depth_d = depth_q;

      case (state_q)
         ST_RUN: begin
            case (major)
               4'h8: begin
                  s_inm = 1'b1;
                  we3   = 1'b1;
               end
               4'h9: s_inc = 1'b0;
               4'hA: s_inc = ~z;
               4'hB: s_inc = z;
               4'hC: s_inc = ~carry;
               4'hD: s_inc = carry;
               4'hE: begin
                  if (!stack_full) begin
                     push    = 1'b1;
                     s_inc   = 1'b0;
                     depth_d = depth_q + 4'd1;
                  end else begin
                     state_d = ST_FAULT;
                  end
               end
               4'hF: begin
                  case (sub)
                     4'h0: begin
                        if (!stack_empty) begin
                           pop     = 1'b1;
                           depth_d = depth_q - 4'd1;
                        end else begin
                           state_d = ST_FAULT;
                        end
                     end
                     4'h1: begin
                        pc_en   = 1'b0;
                        state_d = ST_HALT;
                     end
                     4'h2: begin
                        pc_en   = 1'b0;
                        state_d = ST_WAIT;
                     end
                     default: ;
                  endcase
               end
               default: begin
                  // major 0..7: the low three bits select the ALU operation
                  op_alu = opcode[14:12];
                  we3    = 1'b1;
                  wez    = 1'b1;
               end
            endcase
         end
         ST_WAIT: begin
            pc_en = 1'b0;
            if (ev_req) begin
               ev_ack  = 1'b1;
               pc_en   = 1'b1;
               state_d = ST_RUN;
            end
         end
         ST_HALT:  pc_en = 1'b0;
         ST_FAULT: pc_en = 1'b0;
         default:  pc_en = 1'b0;
      endcase

      // Reset overrides every decode result, including a pending event.
      if (reset) begin
         s_inc   = 1'b1;
         s_inm   = 1'b0;
         we3     = 1'b0;
         wez     = 1'b0;
         push    = 1'b0;
         pop     = 1'b0;
         op_alu  = 3'b000;
         pc_en   = 1'b1;
         ev_ack  = 1'b0;
         state_d = ST_RUN;
         depth_d = 4'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_RUN;
         depth_q <= 4'd0;
      end else begin
         state_q <= state_d;
         depth_q <= depth_d;
      end
   end

   assign halted = (state_q == ST_HALT);
   assign fault  = (state_q == ST_FAULT);
   assign depth  = depth_q;

endmodule

// File: tb/tb_ctrl_unit.sv
// Bench for ctrl_unit: table of single-cycle vectors plus hand sequences; expectations queued at drive time.
module tb_ctrl_unit;

   typedef struct packed {
      logic       s_inc;
      logic       s_inm;
      logic       we3;
      logic       wez;
      logic       push;
      logic       pop;
      logic [2:0] op_alu;
      logic       pc_en;
      logic       ev_ack;
      logic       halted;
      logic       fault;
      logic [3:0] depth;
   } outs_t;

   typedef struct {
      string       name;
      logic        rst;
      logic [15:0] op;
      logic        z;
      logic        c;
      logic        ev;
      outs_t       exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset, z, carry, ev_req;
   logic [15:0] opcode;
   logic        s_inc, s_inm, we3, wez, push, pop, pc_en, ev_ack, halted, fault;
   logic [2:0]  op_alu;
   logic [3:0]  depth;
   outs_t       act;

   outs_t exp_q[$];
   string name_q[$];
   int    n_checks = 0;
   int    n_fail   = 0;

   always #5 clk = ~clk;

   ctrl_unit #(.STACK_DEPTH(8)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .z(z), .carry(carry), .ev_req(ev_req),
      .s_inc(s_inc), .s_inm(s_inm), .we3(we3), .wez(wez), .push(push), .pop(pop),
      .op_alu(op_alu), .pc_en(pc_en), .ev_ack(ev_ack), .halted(halted), .fault(fault),
      .depth(depth)
   );

   assign act = {s_inc, s_inm, we3, wez, push, pop, op_alu, pc_en, ev_ack, halted, fault, depth};

   function automatic outs_t base(input logic [3:0] d);
      outs_t o;
      o       = '0;
      o.s_inc = 1'b1;
      o.pc_en = 1'b1;
      o.depth = d;
      return o;
   endfunction

   function automatic outs_t alu(input logic [2:0] f, input logic [3:0] d);
      outs_t o;
      o        = base(d);
      o.op_alu = f;
      o.we3    = 1'b1;
      o.wez    = 1'b1;
      return o;
   endfunction

   function automatic outs_t stalled(input logic [3:0] d);
      outs_t o;
      o       = base(d);
      o.pc_en = 1'b0;
      return o;
   endfunction

   function automatic vec_t v(input string nm, input logic r, input logic [15:0] op,
                              input logic zz, input logic cc, input logic ev, input outs_t e);
      vec_t t;
      t.name = nm; t.rst = r; t.op = op; t.z = zz; t.c = cc; t.ev = ev; t.exp = e;
      return t;
   endfunction

   task automatic drive(input string nm, input logic r, input logic [15:0] op,
                        input logic zz, input logic cc, input logic ev, input outs_t e);
      @(posedge clk);
      #1;
      reset  = r;
      opcode = op;
      z      = zz;
      carry  = cc;
      ev_req = ev;
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   always @(negedge clk) begin
      outs_t e;
      string nm;
      if (exp_q.size() > 0) begin
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
         n_checks++;
         if (act !== e) begin
            n_fail++;
            $display("FAIL %s: got %b required %b (s_inc s_inm we3 wez push pop op_alu pc_en ev_ack halted fault depth)",
                     nm, act, e);
         end
      end
   end

   initial begin
      vec_t  tbl[$];
      outs_t e;

      reset = 1'b1; opcode = 16'h0000; z = 1'b0; carry = 1'b0; ev_req = 1'b0;
      repeat (2) @(posedge clk);

      tbl.push_back(v("rst_state",       1, 16'h3000, 0, 0, 0, base(0)));
      tbl.push_back(v("rst_forced_call", 1, 16'hE000, 0, 0, 1, base(0)));
      tbl.push_back(v("alu_3000",        0, 16'h3000, 0, 0, 0, alu(3'b011, 0)));
      tbl.push_back(v("alu_7000",        0, 16'h7000, 0, 0, 0, alu(3'b111, 0)));
      e = base(0); e.s_inm = 1; e.we3 = 1;
      tbl.push_back(v("ldi_8000",        0, 16'h8000, 0, 0, 0, e));
      e = base(0); e.s_inc = 0;
      tbl.push_back(v("jmp",             0, 16'h9000, 0, 0, 0, e));
      tbl.push_back(v("jz_z1",           0, 16'hA000, 1, 0, 0, e));
      tbl.push_back(v("jz_z0",           0, 16'hA000, 0, 0, 0, base(0)));
      tbl.push_back(v("jnz_z1",          0, 16'hB000, 1, 0, 0, base(0)));
      tbl.push_back(v("jnz_z0",          0, 16'hB000, 0, 0, 0, e));
      tbl.push_back(v("jc_c1",           0, 16'hC000, 0, 1, 0, e));
      tbl.push_back(v("jnc_c0",          0, 16'hD000, 0, 0, 0, e));
      tbl.push_back(v("jnc_c1",          0, 16'hD000, 0, 1, 0, base(0)));
      tbl.push_back(v("nop_f300",        0, 16'hF300, 0, 0, 0, base(0)));
      e = base(0); e.push = 1; e.s_inc = 0;
      tbl.push_back(v("call_d0",         0, 16'hE000, 0, 0, 0, e));
      e.depth = 1;
      tbl.push_back(v("call_d1",         0, 16'hE000, 0, 0, 0, e));
      e = base(2); e.pop = 1;
      tbl.push_back(v("ret_d2",          0, 16'hF000, 0, 0, 0, e));
      e.depth = 1;
      tbl.push_back(v("ret_d1",          0, 16'hF000, 0, 0, 0, e));
      tbl.push_back(v("ret_d0_underflow",0, 16'hF000, 0, 0, 0, base(0)));
      e = stalled(0); e.fault = 1;
      tbl.push_back(v("fault_sticky",    0, 16'h3000, 0, 0, 1, e));
      e = base(0); e.fault = 1;
      tbl.push_back(v("rst_in_fault",    1, 16'h3000, 0, 0, 1, e));
      tbl.push_back(v("after_fault_rst", 0, 16'h3000, 0, 0, 0, alu(3'b011, 0)));

      foreach (tbl[i])
         drive(tbl[i].name, tbl[i].rst, tbl[i].op, tbl[i].z, tbl[i].c, tbl[i].ev, tbl[i].exp);

      // Stack overflow: eight pushes, then the ninth CALL faults.
      for (int i = 0; i < 8; i++) begin
         e = base(4'(i)); e.push = 1; e.s_inc = 0;
         drive("call_fill", 0, 16'hE000, 0, 0, 0, e);
      end
      drive("call_overflow", 0, 16'hE000, 0, 0, 0, base(8));
      e = stalled(8); e.fault = 1;
      drive("overflow_fault", 0, 16'hE000, 0, 0, 0, e);
      drive("fault_ret_frozen", 0, 16'hF000, 0, 0, 1, e);
      e = base(8); e.fault = 1;
      drive("rst_overflow", 1, 16'hE000, 0, 0, 0, e);
      drive("after_ovf_rst", 0, 16'hF300, 0, 0, 0, base(0));

      // RET at depth 3.
      for (int i = 0; i < 3; i++) begin
         e = base(4'(i)); e.push = 1; e.s_inc = 0;
         drive("call_to3", 0, 16'hE000, 0, 0, 0, e);
      end
      e = base(3); e.pop = 1;
      drive("ret_d3", 0, 16'hF000, 0, 0, 0, e);
      drive("depth_after_ret", 0, 16'hF300, 0, 0, 0, base(2));

      // WAIT with a late event: six stalled cycles, one ack, then RUN.
      drive("wait_instr", 0, 16'hF200, 0, 0, 0, stalled(2));
      for (int i = 0; i < 5; i++)
         drive("wait_idle", 0, 16'hF200, 0, 0, 0, stalled(2));
      e = base(2); e.ev_ack = 1;
      drive("wait_ack", 0, 16'hF200, 0, 0, 1, e);
      drive("wait_ack_once", 0, 16'h3000, 0, 0, 1, alu(3'b011, 2));

      // WAIT with event already present: acknowledged one cycle later.
      drive("wait_ev_entry", 0, 16'hF200, 0, 0, 1, stalled(2));
      drive("wait_ev_ack", 0, 16'hF200, 0, 0, 1, e);
      drive("wait_ev_run", 0, 16'hF300, 0, 0, 0, base(2));

      // Reset beats a simultaneous event inside WAIT.
      drive("wait_again", 0, 16'hF200, 0, 0, 0, stalled(2));
      drive("rst_in_wait", 1, 16'hF200, 0, 0, 1, base(2));
      drive("after_wait_rst", 0, 16'hF300, 0, 0, 0, base(0));

      // HALT held until reset.
      drive("halt_instr", 0, 16'hF100, 0, 0, 0, stalled(0));
      e = stalled(0); e.halted = 1;
      drive("halted_ev_ignored", 0, 16'hF100, 0, 0, 1, e);
      drive("halted_call", 0, 16'hE000, 0, 0, 0, e);
      e = base(0); e.halted = 1;
      drive("rst_in_halt", 1, 16'hF100, 0, 0, 1, e);
      drive("after_halt_rst", 0, 16'hF300, 0, 0, 0, base(0));

      for (int i = 0; i < 10 && exp_q.size() > 0; i++)
         @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d checks pending, required 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ctrl_unit.md
CTRL_UNIT -- requirements
Module: ctrl_unit

Interface
REQ-001 Parameter: STACK_DEPTH, 8, hardware return-stack entry count that the block tracks (1..15).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 opcode  in  16  current instruction field INST[31:16] from the datapath.
REQ-005 z  in  1  registered zero flag from the datapath.
REQ-006 carry  in  1  registered carry flag from the datapath.
REQ-007 ev_req  in  1  external event request; level, held until ev_ack.
REQ-008 s_inc, s_inm, we3, wez, push, pop  out  1 each  datapath controls: 1 = PC+1 / immediate / regfile write / flag write / stack push / stack pop.
REQ-009 op_alu  out  3  ALU operation select.
REQ-010 pc_en  out  1  PC update enable; 0 holds PC and current instruction.
REQ-011 ev_ack  out  1  one-cycle event acknowledge.
REQ-012 halted, fault  out  1 each  status: halt executed / stack fault latched.
REQ-013 depth  out  4  current return-stack occupancy.

Function
REQ-014 Major field = opcode[15:12]; sub field = opcode[11:8]; decode is combinational from opcode, z, carry and state.
REQ-015 Control outputs SHALL default to 0 (op_alu 000, s_inc 1, pc_en 1) in RUN except as listed below.
REQ-016 0xxx ALU op: op_alu=opcode[14:12], we3=1, wez=1.
REQ-017 1000 load immediate: s_inm=1, we3=1, op_alu=000, wez=0.
REQ-018 1001 JMP: s_inc=0; 1010 JZ: s_inc=~z; 1011 JNZ: s_inc=z; 1100 JC: s_inc=~carry; 1101 JNC: s_inc=carry.
REQ-019 1110 CALL: if depth<STACK_DEPTH then push=1, s_inc=0, depth+1; else enter FAULT, push=0.
REQ-020 1111/0000 RET: if depth>0 then pop=1, depth-1; else enter FAULT, pop=0.
REQ-021 1111/0001 HALT: pc_en=0 this cycle; next state HALT.
REQ-022 1111/0010 WAIT: pc_en=0 this cycle; next state WAIT.
REQ-023 1111/other: NOP (s_inc=1, no writes).
REQ-024 States: RUN, WAIT, HALT, FAULT; 2-bit encoded register.
REQ-025 WAIT: pc_en=0, all writes 0; when ev_req=1: ev_ack=1 same cycle, pc_en=1, s_inc=1, next RUN.
REQ-026 WAIT with ev_req already 1 on entry: acknowledged on the first WAIT cycle (one cycle after the WAIT instruction), never same cycle.
REQ-027 HALT: pc_en=0, all writes 0, halted=1; exits only on reset; ev_req ignored.
REQ-028 FAULT: pc_en=0, all writes/push/pop 0, fault=1; sticky until reset; depth frozen.
REQ-029 push and pop SHALL never both be 1; we3/wez SHALL be 0 whenever pc_en=0.
REQ-030 depth counts 0..STACK_DEPTH with no wrap; updates only when push or pop is issued.
REQ-031 ev_ack SHALL be 1 for exactly one cycle per accepted event.

Reset
REQ-032 reset=1 at a clock edge: state=RUN, depth=0, halted=0, fault=0, ev_ack=0.
REQ-033 While reset=1, outputs SHALL be forced to: we3=0, wez=0, push=0, pop=0, s_inc=1, pc_en=1, s_inm=0, op_alu=000.
REQ-034 Reset takes priority over all events, including mid-WAIT, HALT, FAULT and simultaneous ev_req.

Verification
REQ-035 opcode 0x3000 in RUN -> op_alu=011, we3=1, wez=1, s_inc=1, pc_en=1.
REQ-036 JZ (0xA000) with z=1 -> s_inc=0; with z=0 -> s_inc=1; JNC with carry=0 -> s_inc=0.
REQ-037 8 consecutive CALLs (0xE000) -> depth 1..8, push each cycle; 9th CALL -> push=0, fault=1 next cycle, pc_en=0 thereafter.
REQ-038 RET (0xF000) at depth 0 -> pop=0, fault=1 next cycle; RET at depth 3 -> pop=1, depth=2.
REQ-039 WAIT (0xF200), ev_req held 0 for 5 cycles then 1 -> pc_en=0 for 6 cycles, ev_ack=1 single cycle, then RUN.
REQ-040 HALT (0xF100) then reset asserted 1 cycle -> halted=1 until reset edge, then halted=0, depth=0, state RUN.
